// File: rtl/zstr_fifo_pkg.sv
// Shared helpers for the zstr_* stream blocks: constant clog2 and the zbus
// transfer predicate.
`timescale 1ns/1ps
package zstr_fifo_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic zb_xfer(input logic vld, input logic ack);
        return vld & ack;
    endfunction

endpackage

// File: rtl/zstr_fifo_mem.sv
// DEPTH x BW register array: synchronous write, asynchronous read, no reset.
`timescale 1ns/1ps
module zstr_fifo_mem #(
    parameter int BW    = 8,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          z_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [BW-1:0] rdata
);

    logic [BW-1:0] mem_q [DEPTH];

    always_ff @(posedge z_clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/zstr_fifo.sv
// zbus stream FIFO: DEPTH entries, optional registered input ack (RI) and
// optional zero-latency fall-through output (RO=0).
`timescale 1ns/1ps
module zstr_fifo
    import zstr_fifo_pkg::*;
#(
    parameter int BW    = 0,
    parameter int DEPTH = 2,
    parameter int RI    = 1,
    parameter int RO    = 1,
    localparam int CW   = clog2(DEPTH + 1)
) (
    input  logic          z_clk,
    input  logic          z_rst,
    input  logic          z_clr,
    input  logic          zi_vld,
    input  logic [BW-1:0] zi_bus,
    output logic          zi_ack,
    output logic          zo_vld,
    output logic [BW-1:0] zo_bus,
    input  logic          zo_ack,
    output logic [CW-1:0] z_cnt
);

    localparam int            AW       = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [BW-1:0] mem_rdata;
    logic          empty_n;
    logic          in_ok;
    logic          bypass;
    logic          xfer_in;
    logic          xfer_out;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    assign empty_n  = (cnt_q != '0);
    assign xfer_in  = zb_xfer(zi_vld, zi_ack) & ~bypass;
    assign xfer_out = zb_xfer(zo_vld, zo_ack) & ~bypass;
    assign cnt_nxt  = cnt_q + CW'(xfer_in) - CW'(xfer_out);
    assign z_cnt    = cnt_q;

    always_ff @(posedge z_clk or posedge z_rst) begin
        if (z_rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (z_clr) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            if (xfer_in)  wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (xfer_out) rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    zstr_fifo_mem #(
        .BW    (BW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .z_clk (z_clk),
        .we    (xfer_in & ~z_clr),
        .waddr (wr_ptr_q),
        .wdata (zi_bus),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // in_ok never depends on zo_ack, so the fall-through valid stays ack-independent
    generate
        if (RI != 0) begin : g_ri
            logic rdy_q;
            always_ff @(posedge z_clk or posedge z_rst) begin
                if (z_rst)      rdy_q <= 1'b0;
                else if (z_clr) rdy_q <= 1'b1;
                else            rdy_q <= (cnt_nxt < FULL_CNT);
            end
            assign in_ok  = rdy_q;
            assign zi_ack = rdy_q;
        end else begin : g_nri
            assign in_ok  = (cnt_q < FULL_CNT);
            assign zi_ack = in_ok | zo_ack;
        end

        if (RO != 0) begin : g_ro
            assign bypass = 1'b0;
            assign zo_vld = empty_n;
            assign zo_bus = mem_rdata;
        end else begin : g_nro
            logic fall_vld;
            assign fall_vld = zi_vld & in_ok & ~z_rst & ~z_clr;
            assign bypass   = ~empty_n & fall_vld & zo_ack;
            assign zo_vld   = empty_n | fall_vld;
            assign zo_bus   = empty_n ? mem_rdata : zi_bus;
        end
    endgenerate

endmodule

// File: tb/tb_zstr_fifo.sv
// Directed bench: instance a (DEPTH=4 RI=1 RO=1) and instance b (DEPTH=4 RI=0 RO=0).
`timescale 1ns/1ps
module tb_zstr_fifo;

    logic       z_clk;
    logic       z_rst;
    logic       a_clr, a_vld, a_iack, a_ovld, a_oack;
    logic [7:0] a_bus, a_obus;
    logic [2:0] a_cnt;
    logic       b_clr, b_vld, b_iack, b_ovld, b_oack;
    logic [7:0] b_bus, b_obus;
    logic [2:0] b_cnt;

    int checks = 0;
    int errors = 0;

    zstr_fifo #(.BW(8), .DEPTH(4), .RI(1), .RO(1)) dut_a (
        .z_clk  (z_clk),
        .z_rst  (z_rst),
        .z_clr  (a_clr),
        .zi_vld (a_vld),
        .zi_bus (a_bus),
        .zi_ack (a_iack),
        .zo_vld (a_ovld),
        .zo_bus (a_obus),
        .zo_ack (a_oack),
        .z_cnt  (a_cnt)
    );

    zstr_fifo #(.BW(8), .DEPTH(4), .RI(0), .RO(0)) dut_b (
        .z_clk  (z_clk),
        .z_rst  (z_rst),
        .z_clr  (b_clr),
        .zi_vld (b_vld),
        .zi_bus (b_bus),
        .zi_ack (b_iack),
        .zo_vld (b_ovld),
        .zo_bus (b_obus),
        .zo_ack (b_oack),
        .z_cnt  (b_cnt)
    );

    initial z_clk = 1'b0;
    always #5 z_clk = ~z_clk;

    task automatic tick();
        @(posedge z_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        z_rst = 1'b1;
        a_clr = 0; a_vld = 0; a_bus = 0; a_oack = 0;
        b_clr = 0; b_vld = 0; b_bus = 0; b_oack = 0;

        // reset state
        #2;
        chk("a_rst_iack", a_iack, 0);
        chk("a_rst_ovld", a_ovld, 0);
        chk("a_rst_cnt",  a_cnt,  0);
        chk("b_rst_ovld", b_ovld, 0);
        chk("b_rst_cnt",  b_cnt,  0);
        tick(); tick();
        z_rst = 1'b0;
        #1;
        chk("a_iack_after_release", a_iack, 0);
        tick();
        chk("a_iack_first_edge", a_iack, 1);

        // ordered transfer, latency 1
        a_vld = 1; a_bus = 8'h11;
        #1;
        chk("a_lat_ovld_pre", a_ovld, 0);
        tick();
        chk("a_lat_ovld_post", a_ovld, 1);
        chk("a_lat_obus",      a_obus, 8'h11);
        a_bus = 8'h22; tick();
        a_bus = 8'h33; tick();
        a_vld = 0;
        chk("t1_cnt",  a_cnt,  3);
        chk("t1_ovld", a_ovld, 1);
        chk("t1_obus", a_obus, 8'h11);
        a_oack = 1;
        tick(); chk("t1_out2", a_obus, 8'h22); chk("t1_cnt2", a_cnt, 2);
        tick(); chk("t1_out3", a_obus, 8'h33); chk("t1_cnt1", a_cnt, 1);
        tick(); chk("t1_empty_vld", a_ovld, 0); chk("t1_empty_cnt", a_cnt, 0);
        a_oack = 0;

        // fill to full, 5th word held
        a_vld = 1;
        for (int i = 0; i < 4; i++) begin
            a_bus = 8'h41 + 8'(i);
            tick();
        end
        chk("t2_cnt_full", a_cnt,  4);
        chk("t2_iack_low", a_iack, 0);
        a_bus = 8'h45;
        tick(); tick();
        chk("t2_cnt_hold", a_cnt,  4);
        chk("t2_iack_hold", a_iack, 0);
        chk("t2_head",     a_obus, 8'h41);

        // full with continuous traffic, 1-cycle ready recovery
        a_oack = 1;
        tick();
        chk("t3_recover_iack", a_iack, 1);
        chk("t3_recover_cnt",  a_cnt,  3);
        chk("t3_recover_bus",  a_obus, 8'h42);
        tick();
        chk("t3_s1_cnt", a_cnt, 3); chk("t3_s1_bus", a_obus, 8'h43);
        a_bus = 8'h46; tick();
        chk("t3_s2_cnt", a_cnt, 3); chk("t3_s2_bus", a_obus, 8'h44);
        a_bus = 8'h47; tick();
        chk("t3_s3_cnt", a_cnt, 3); chk("t3_s3_bus", a_obus, 8'h45);
        a_vld = 0;
        tick(); chk("t3_d1_bus", a_obus, 8'h46); chk("t3_d1_cnt", a_cnt, 2);
        tick(); chk("t3_d2_bus", a_obus, 8'h47); chk("t3_d2_cnt", a_cnt, 1);
        tick(); chk("t3_d3_vld", a_ovld, 0);     chk("t3_d3_cnt", a_cnt, 0);
        a_oack = 0;

        // synchronous clear discards the word offered in the clear cycle
        a_vld = 1;
        a_bus = 8'h51; tick();
        a_bus = 8'h52; tick();
        a_bus = 8'h53; tick();
        chk("t5_cnt_pre", a_cnt, 3);
        a_clr = 1; a_bus = 8'h77;
        tick();
        a_clr = 0; a_vld = 0;
        chk("t5_cnt",  a_cnt,  0);
        chk("t5_ovld", a_ovld, 0);
        chk("t5_iack", a_iack, 1);
        a_vld = 1; a_bus = 8'h88;
        tick();
        a_vld = 0;
        chk("t5_next_cnt", a_cnt,  1);
        chk("t5_next_bus", a_obus, 8'h88);
        a_oack = 1; tick(); a_oack = 0;
        chk("t5_drain_cnt", a_cnt, 0);

        // asynchronous reset mid-stream
        a_vld = 1;
        a_bus = 8'h61; tick();
        a_bus = 8'h62; tick();
        a_vld = 0;
        chk("t6_cnt_pre",  a_cnt,  2);
        chk("t6_ovld_pre", a_ovld, 1);
        #2 z_rst = 1'b1;
        #1;
        chk("t6_ovld_async", a_ovld, 0);
        chk("t6_cnt_async",  a_cnt,  0);
        chk("t6_iack_async", a_iack, 0);
        tick();
        z_rst = 1'b0;
        #1;
        chk("t6_iack_released", a_iack, 0);
        tick();
        chk("t6_iack_edge", a_iack, 1);
        chk("t6_ovld_edge", a_ovld, 0);

        // fall-through bypass on instance b
        b_vld = 1; b_bus = 8'hA5; b_oack = 1;
        #1;
        chk("t4_ovld", b_ovld, 1);
        chk("t4_obus", b_obus, 8'hA5);
        chk("t4_iack", b_iack, 1);
        tick();
        chk("t4_cnt", b_cnt, 0);

        // fall-through without ack stores the word
        b_oack = 0; b_bus = 8'hB1;
        #1;
        chk("b_ft_ovld", b_ovld, 1);
        chk("b_ft_obus", b_obus, 8'hB1);
        tick();
        chk("b_ft_cnt", b_cnt, 1);
        b_bus = 8'hB2; tick();
        b_bus = 8'hB3; tick();
        b_bus = 8'hB4; tick();
        chk("b_full_cnt", b_cnt, 4);
        b_bus = 8'hB5;
        #1;
        chk("b_full_iack", b_iack, 0);
        b_oack = 1;
        #1;
        chk("b_full_iack_rd", b_iack, 1);
        chk("b_full_head",    b_obus, 8'hB1);
        tick();
        chk("b_s1_cnt", b_cnt, 4); chk("b_s1_bus", b_obus, 8'hB2);
        b_bus = 8'hB6; tick();
        chk("b_s2_cnt", b_cnt, 4); chk("b_s2_bus", b_obus, 8'hB3);
        b_vld = 0;
        tick(); chk("b_d1_bus", b_obus, 8'hB4); chk("b_d1_cnt", b_cnt, 3);
        tick(); chk("b_d2_bus", b_obus, 8'hB5); chk("b_d2_cnt", b_cnt, 2);
        tick(); chk("b_d3_bus", b_obus, 8'hB6); chk("b_d3_cnt", b_cnt, 1);
        tick(); chk("b_d4_vld", b_ovld, 0);     chk("b_d4_cnt", b_cnt, 0);

        // clear suppresses the bypass path
        b_clr = 1; b_vld = 1; b_bus = 8'hC3; b_oack = 1;
        #1;
        chk("b_clr_ovld", b_ovld, 0);
        tick();
        b_clr = 0; b_vld = 0; b_oack = 0;
        chk("b_clr_cnt", b_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
